vector_cmd_decoder: RTL and testbench

//  Upstream feeder of the line drawer. Accepts HP1349A-style 16-bit vector words and buffers them in a FIFO.

---
 rtl/vector_cmd_decoder_pkg.sv | 31 +++
 rtl/vector_cmd_decoder_if.sv | 31 +++
 rtl/vector_cmd_decoder_cmd_fifo.sv | 52 +++++
 rtl/vector_cmd_decoder.sv | 195 +++++++++++++++++++
 tb/tb_vector_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_cmd_decoder_pkg.sv
// Shared definitions for the vector command decoder (the vcd_defs set):
//   - opcode constants for the top two bits of a vector word
//   - FSM state encoding
//   - screen geometry
//   - the display-unit to pixel scaler
// No ports; imported by the decoder top level.
package vector_cmd_decoder_pkg;

  localparam logic [1:0] OP_X   = 2'b01;
  localparam logic [1:0] OP_Y   = 2'b10;
  localparam logic [1:0] OP_CTL = 2'b11;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StIssue,
    StWaitStart,
    StWaitDone
  } state_e;

  // 2048 du -> 640 px is a factor of 5/16; computed as (v + 4v) >> 4 in 14 bits.
  function automatic logic [9:0] scale_du(input logic [10:0] v);
    logic [13:0] t;
    t = {3'b000, v} + {1'b0, v, 2'b00};
    return t[13:4];
  endfunction

endpackage

// File: rtl/vector_cmd_decoder_if.sv
// Bundle between the command source / line drawer side and the decoder.
//   cmd_data, cmd_valid, cmd_ready : vector word stream into the decoder FIFO
//   x_from, y_from, x_to, y_to     : segment coordinates in pixels (0,0 = top-left)
//   draw_enable                    : single-cycle segment request to the drawer
//   busy                           : drawer busy, rises the cycle after draw_enable is taken
// Modports:
//   master : the environment (word source plus drawer)
//   slave  : the decoder
interface vector_cmd_decoder_if;

  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  x_from;
  logic [9:0]  y_from;
  logic [9:0]  x_to;
  logic [9:0]  y_to;
  logic        draw_enable;
  logic        busy;

  modport master (
    output cmd_data, cmd_valid, busy,
    input  cmd_ready, x_from, y_from, x_to, y_to, draw_enable
  );

  modport slave (
    input  cmd_data, cmd_valid, busy,
    output cmd_ready, x_from, y_from, x_to, y_to, draw_enable
  );

endinterface

// File: rtl/vector_cmd_decoder_cmd_fifo.sv
// vcd_cmd_fifo: synchronous FIFO for vector command words.
// Ports:
//   clk25, rst    : clock, asynchronous active-high reset (empties the FIFO)
//   push_req      : write request; ignored while full
//   wdata         : word to write
//   pop_req       : read request; ignored while empty
//   rdata         : head-of-queue word (valid while !empty)
//   full, empty   : status flags
// Push and pop in the same cycle are both honoured.
module vcd_cmd_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 16
) (
  input  logic         clk25,
  input  logic         rst,
  input  logic         push_req,
  input  logic [W-1:0] wdata,
  input  logic         pop_req,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned Depth = 1 << AW;

  logic [W-1:0] mem [Depth];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         push, pop;

  assign push  = push_req && !full;
  assign pop   = pop_req && !empty;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk25) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vector_cmd_decoder.sv
// vector_cmd_decoder: buffers HP1349A-style 16-bit vector words, tracks the beam
// position in pixels and issues one segment to the line drawer per pen-down move.
// Ports:
//   clk25     : 25 MHz clock
//   rst       : asynchronous active-high reset; aborts any segment, empties the FIFO
//   vec       : command stream and drawer handshake (slave modport)
//   idle      : FIFO empty, FSM in fetch and drawer not busy
//   seg_count : segments issued, wraps at 16 bits (only with VCD_STATS_EN)
// Build option: define VCD_STATS_EN to add the seg_count port and counter.
module vector_cmd_decoder
  import vector_cmd_decoder_pkg::*;
#(
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned Y_MAX_DU = 1535
) (
  input  logic                  clk25,
  input  logic                  rst,
  vector_cmd_decoder_if.slave   vec,
  output logic                  idle
`ifdef VCD_STATS_EN
  ,
  output logic [15:0]           seg_count
`endif
);

  localparam logic [9:0]  YTop = 10'(SCREEN_H - 1);
  localparam logic [10:0] YMax = 11'(Y_MAX_DU);

  state_e      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [9:0]  x_pend_q, x_pend_d;
  logic [9:0]  y_pend_q, y_pend_d;
  logic        pen_q, pen_d;
  logic [9:0]  cur_x_q, cur_x_d;
  logic [9:0]  cur_y_q, cur_y_d;
  logic [9:0]  x_from_q, x_from_d;
  logic [9:0]  y_from_q, y_from_d;
  logic [9:0]  x_to_q, x_to_d;
  logic [9:0]  y_to_q, y_to_d;
  logic        draw_en;

  logic [15:0] fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop;

  logic [10:0] y_clamped;
  logic [9:0]  y_scaled;

  vcd_cmd_fifo #(
    .AW (FIFO_AW),
    .W  (16)
  ) u_fifo (
    .clk25    (clk25),
    .rst      (rst),
    .push_req (vec.cmd_valid),
    .wdata    (vec.cmd_data),
    .pop_req  (fifo_pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign fifo_pop      = (state_q == StFetch) && !fifo_empty;
  assign vec.cmd_ready = !fifo_full;

  // Flip to top-left origin after scaling the clamped Y.
  assign y_clamped = (cmd_q[10:0] > YMax) ? YMax : cmd_q[10:0];
  assign y_scaled  = YTop - scale_du(y_clamped);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    x_pend_d = x_pend_q;
    y_pend_d = y_pend_q;
    pen_d    = pen_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    x_from_d = x_from_q;
    y_from_d = y_from_q;
    x_to_d   = x_to_q;
    y_to_d   = y_to_q;
    draw_en  = 1'b0;

    case (state_q)
      StFetch: begin
        if (!fifo_empty) begin
          cmd_d   = fifo_rdata;
          state_d = StDecode;
        end
      end

      StDecode: begin
        state_d = StFetch;
        case (cmd_q[15:14])
          OP_X: begin
            x_pend_d = scale_du(cmd_q[10:0]);
            pen_d    = cmd_q[13];
          end
          OP_Y: begin
            y_pend_d = y_scaled;
            if (pen_q) begin
              // Zero-length moves are still issued; the drawer plots a pixel.
              x_from_d = cur_x_q;
              y_from_d = cur_y_q;
              x_to_d   = x_pend_q;
              y_to_d   = y_scaled;
              state_d  = StIssue;
            end else begin
              cur_x_d = x_pend_q;
              cur_y_d = y_scaled;
            end
          end
          OP_CTL: begin
            if (cmd_q[13]) begin
              cur_x_d = '0;
              cur_y_d = YTop;
            end
          end
          default: ;
        endcase
      end

      StIssue: begin
        if (!vec.busy) begin
          draw_en = 1'b1;
          state_d = StWaitStart;
        end
      end

      StWaitStart: begin
        if (vec.busy) state_d = StWaitDone;
      end

      StWaitDone: begin
        if (!vec.busy) begin
          cur_x_d = x_to_q;
          cur_y_d = y_to_q;
          state_d = StFetch;
        end
      end

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      cmd_q    <= '0;
      x_pend_q <= '0;
      y_pend_q <= '0;
      pen_q    <= 1'b0;
      cur_x_q  <= '0;
      cur_y_q  <= YTop;
      x_from_q <= '0;
      y_from_q <= '0;
      x_to_q   <= '0;
      y_to_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      x_pend_q <= x_pend_d;
      y_pend_q <= y_pend_d;
      pen_q    <= pen_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      x_from_q <= x_from_d;
      y_from_q <= y_from_d;
      x_to_q   <= x_to_d;
      y_to_q   <= y_to_d;
    end
  end

  assign vec.x_from      = x_from_q;
  assign vec.y_from      = y_from_q;
  assign vec.x_to        = x_to_q;
  assign vec.y_to        = y_to_q;
  assign vec.draw_enable = draw_en;

  assign idle = fifo_empty && (state_q == StFetch) && !vec.busy;

`ifdef VCD_STATS_EN
  logic [15:0] seg_count_q;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      seg_count_q <= '0;
    end else if (draw_en) begin
      seg_count_q <= seg_count_q + 16'd1;
    end
  end

  assign seg_count = seg_count_q;
`endif

endmodule

// File: tb/tb_vector_cmd_decoder.sv
// Directed bench for vector_cmd_decoder with a small line-drawer responder.
module tb_vector_cmd_decoder;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  logic idle;
  logic model_busy = 1'b0;
  logic ext_busy   = 1'b0;
`ifdef VCD_STATS_EN
  logic [15:0] seg_count;
`endif

  vector_cmd_decoder_if vif ();
  assign vif.busy = model_busy | ext_busy;

  vector_cmd_decoder dut (
    .clk25     (clk25),
    .rst       (rst),
    .vec       (vif),
    .idle      (idle)
`ifdef VCD_STATS_EN
    ,
    .seg_count (seg_count)
`endif
  );

  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] seg(input int xf, input int yf, input int xt, input int yt);
    return {10'(xf), 10'(yf), 10'(xt), 10'(yt)};
  endfunction

  // Monitor: every cycle draw_enable is high counts as a pulse and logs coordinates.
  int           de_cycles = 0;
  logic [39:0]  seg_q[$];
  initial forever begin
    @(negedge clk25);
    if (vif.draw_enable === 1'b1) begin
      de_cycles++;
      seg_q.push_back({vif.x_from, vif.y_from, vif.x_to, vif.y_to});
    end
  end

  // Drawer: busy rises the cycle after the request, stays up busy_len cycles or while hold.
  int busy_len = 3;
  bit hold     = 1'b0;
  initial forever begin
    @(negedge clk25);
    if (vif.draw_enable === 1'b1) begin
      int cnt;
      @(posedge clk25);
      #1 model_busy = 1'b1;
      cnt = 0;
      do begin
        @(posedge clk25);
        #1 cnt++;
      end while (cnt < busy_len || hold);
      model_busy = 1'b0;
    end
  end

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Called at a negedge; returns at a negedge after the word was taken.
  task automatic push_word(input logic [15:0] w);
    int t = 0;
    vif.cmd_data  = w;
    vif.cmd_valid = 1'b1;
    while (vif.cmd_ready !== 1'b1 && t < 500) begin
      @(negedge clk25);
      t++;
    end
    check("push_ready", vif.cmd_ready, 1);
    @(negedge clk25);
    vif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk25);
    while (!(idle === 1'b1 && model_busy == 1'b0) && t < 2000) begin
      @(negedge clk25);
      t++;
    end
    check("wait_idle", idle, 1);
  endtask

  task automatic wait_model_busy();
    int t = 0;
    while (model_busy !== 1'b1 && t < 100) begin
      @(negedge clk25);
      t++;
    end
    check("drawer_started", model_busy, 1);
  endtask

  task automatic expect_segs(input string tag, input int n);
    check({tag, "_count"}, seg_q.size(), n);
  endtask

  task automatic expect_seg(input string tag, input logic [39:0] exp);
    if (seg_q.size() > 0) check(tag, seg_q.pop_front(), exp);
  endtask

  initial begin
    int de_before;
    int accepted;
    bit seen;
    bit bad;
    int t;

    vif.cmd_data  = '0;
    vif.cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk25);
    check("rst_draw_enable", vif.draw_enable, 0);
    check("rst_cmd_ready", vif.cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_coords", {vif.x_from, vif.y_from, vif.x_to, vif.y_to}, 0);
    rst = 1'b0;
    @(negedge clk25);

    // Pen-down X=0 then clamped Y=2047: (0,479) -> (0,0).
    seg_q.delete();
    push_word(16'h6000);
    push_word(16'h87FF);
    wait_idle();
    expect_segs("t1", 1);
    expect_seg("t1_seg", seg(0, 479, 0, 0));

    // Pen-up move then pen-down back to origin.
    seg_q.delete();
    push_word(16'h47FF);
    push_word(16'h8000);
    wait_idle();
    expect_segs("t2_penup", 0);
    push_word(16'h6000);
    push_word(16'h8000);
    wait_idle();
    expect_segs("t2_draw", 1);
    expect_seg("t2_seg", seg(639, 479, 0, 479));

    // Pen-up to (320,239), HOME, then pen-down with NOPs between X and Y.
    seg_q.delete();
    push_word(16'h4400);
    push_word(16'h8300);
    push_word(16'hE000);
    push_word(16'h6100);
    push_word(16'h0123);
    push_word(16'hC000);
    push_word(16'h85FF);
    wait_idle();
    expect_segs("home_nop", 1);
    expect_seg("home_nop_seg", seg(0, 479, 80, 0));

    // Drawer busy while in ISSUE: no request until busy drops, then exactly one.
    seg_q.delete();
    ext_busy  = 1'b1;
    de_before = de_cycles;
    push_word(16'h67FF);
    push_word(16'h8300);
    repeat (12) @(negedge clk25);
    check("t3_hold_no_de", de_cycles - de_before, 0);
    check("t3_hold_coords", {vif.x_from, vif.y_from, vif.x_to, vif.y_to},
          {24'd0, seg(80, 0, 639, 239)});
    @(posedge clk25);
    #1 ext_busy = 1'b0;
    @(negedge clk25);
    check("t3_pulse_now", vif.draw_enable, 1);
    wait_model_busy();
    bad = 1'b0;
    t   = 0;
    while (vif.busy === 1'b1 && t < 50) begin
      if ({vif.x_from, vif.y_from, vif.x_to, vif.y_to} !== seg(80, 0, 639, 239)) bad = 1'b1;
      @(negedge clk25);
      t++;
    end
    check("t3_stable", bad, 0);
    wait_idle();
    check("t3_one_pulse", de_cycles - de_before, 1);
    expect_seg("t3_seg", seg(80, 0, 639, 239));

    // Stalled drawer: FIFO takes 16 words, the rest wait; nothing lost on release.
    seg_q.delete();
    push_word(16'hE000);
    hold = 1'b1;
    push_word(16'h6000);
    push_word(16'h8000);
    wait_model_busy();
    repeat (2) @(negedge clk25);
    accepted = 0;
    seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      int k;
      k = i / 2 + 1;
      if (vif.cmd_ready !== 1'b1 && !seen) begin
        seen = 1'b1;
        check("t4_accepted_before_full", accepted, 16);
        hold = 1'b0;
      end
      if (i % 2 == 0) push_word(16'h6000 | 16'(160 * k));
      else            push_word(16'h8000 | 16'(128 * k));
      accepted++;
    end
    check("t4_full_seen", seen, 1);
    hold = 1'b0;
    wait_idle();
    expect_segs("t4", 11);
    expect_seg("t4_stall_seg", seg(0, 479, 0, 479));
    for (int k = 1; k <= 10; k++) begin
      expect_seg($sformatf("t4_seg%0d", k),
                 seg(50 * (k - 1), 479 - 40 * (k - 1), 50 * k, 479 - 40 * k));
    end

    // Reset during WAIT_DONE with words queued.
    seg_q.delete();
    hold = 1'b1;
    push_word(16'h60A0);
    push_word(16'h8000);
    wait_model_busy();
    repeat (2) @(negedge clk25);
    push_word(16'h6100);
    push_word(16'h8100);
    de_before = de_cycles;
    rst  = 1'b1;
    hold = 1'b0;
    @(negedge clk25);
    check("t5_draw_enable", vif.draw_enable, 0);
    check("t5_cmd_ready", vif.cmd_ready, 1);
    check("t5_idle", idle, 1);
    check("t5_coords", {vif.x_from, vif.y_from, vif.x_to, vif.y_to}, 0);
    repeat (2) @(negedge clk25);
    rst = 1'b0;
    repeat (30) @(negedge clk25);
    check("t5_no_stale_issue", de_cycles - de_before, 0);

    // Y with no preceding X after reset: pen up, x_pend 0.
    seg_q.delete();
    push_word(16'h8400);
    wait_idle();
    expect_segs("t5_y_only", 0);
    push_word(16'h6100);
    push_word(16'h8000);
    wait_idle();
    expect_segs("t5_after", 1);
    expect_seg("t5_after_seg", seg(0, 159, 80, 479));

`ifdef VCD_STATS_EN
    @(negedge clk25);
    force dut.seg_count_q = 16'hFFFF;
    @(negedge clk25);
    release dut.seg_count_q;
    check("t6_preload", seg_count, 16'hFFFF);
    push_word(16'h6000);
    push_word(16'h8000);
    wait_idle();
    check("t6_wrap", seg_count, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
